// File: rtl/led_status_arbiter_if.sv
// Bundle between the status sources and the LED arbiter.
// Optional macro: LED_BLINK_EN adds the per-source blink request.
// The master side is the group of status sources. The slave side is the arbiter.
interface led_status_arbiter_if #(
  parameter int N_REQ = 4
);

  logic [N_REQ-1:0]         req;
  logic [10*N_REQ-1:0]      pattern;
`ifdef LED_BLINK_EN
  logic [N_REQ-1:0]         blink;
`endif
  logic [N_REQ-1:0]         ack;
  logic [$clog2(N_REQ)-1:0] grant_id;
  logic                     busy;
  logic [9:0]               led_out;

  modport master (
    output req,
    output pattern,
`ifdef LED_BLINK_EN
    output blink,
`endif
    input  ack,
    input  grant_id,
    input  busy,
    input  led_out
  );

  modport slave (
    input  req,
    input  pattern,
`ifdef LED_BLINK_EN
    input  blink,
`endif
    output ack,
    output grant_id,
    output busy,
    output led_out
  );

endinterface

// File: rtl/led_status_arbiter.sv
// Round-robin arbiter that shares the 10 user LEDs between status sources.
// Each grant is shown for at least HOLD_CYCLES clocks. When no source holds
// a grant, the LEDs show IDLE_PATTERN. led_out is active-high and feeds the
// existing LED inversion stage.
// Optional macro: LED_BLINK_EN. When it is defined, a source can ask for its
// pattern to blink, toggling every BLINK_DIV clocks.
module led_status_arbiter #(
  parameter int         N_REQ        = 4,
  parameter int         HOLD_CYCLES  = 25000000,
  parameter logic [9:0] IDLE_PATTERN = 10'b0000000001
`ifdef LED_BLINK_EN
  ,
  parameter int         BLINK_DIV    = 6250000
`endif
) (
  input logic                clk,
  input logic                reset_n,
  led_status_arbiter_if.slave bus
);

  localparam int PW = $clog2(N_REQ);
  localparam int DW = $clog2(HOLD_CYCLES + 1);
  localparam logic [DW-1:0] HOLD_LOAD = DW'(HOLD_CYCLES - 1);
  localparam logic [PW-1:0] LAST_ID   = PW'(N_REQ - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  state_t           state_q,  state_d;
  logic [DW-1:0]    dwell_q,  dwell_d;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [9:0]       led_q,    led_d;
  logic [N_REQ-1:0] ack_q,    ack_d;
  logic [PW-1:0]    grant_q,  grant_d;
  logic             busy_q,   busy_d;

`ifdef LED_BLINK_EN
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV);

  // Latched copy of the granted pattern. led_out alternates between this
  // copy and all-off, so the copy must be kept on its own.
  logic [9:0]    latched_q,  latched_d;
  logic          blink_en_q, blink_en_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic [BW-1:0] blink_cnt_inc;
  logic          blink_off_q, blink_off_d;
`endif

  logic          win_valid;
  logic [PW-1:0] win_id;
  logic          take;

  // Round-robin pick: first requester at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    win_valid = 1'b0;
    win_id    = '0;
    // The scan runs from the farthest offset back to offset 0, so the last
    // hit written is the closest requester to rr_ptr.
    for (int off = N_REQ - 1; off >= 0; off--) begin
      if (bus.req[(int'(rr_ptr_q) + off) % N_REQ]) begin
        win_valid = 1'b1;
        win_id    = PW'((int'(rr_ptr_q) + off) % N_REQ);
      end
    end
  end

  // Next-state and next-output logic for the IDLE/SHOW controller.
  always_comb begin
    // NOTE: every variable gets a default first. Without it, a path that
    // does not assign the variable would infer a latch.
    state_d  = state_q;
    dwell_d  = dwell_q;
    rr_ptr_d = rr_ptr_q;
    led_d    = led_q;
    ack_d    = '0;
    grant_d  = grant_q;
    busy_d   = busy_q;
    take     = 1'b0;
`ifdef LED_BLINK_EN
    latched_d     = latched_q;
    blink_en_d    = blink_en_q;
    blink_cnt_d   = blink_cnt_q;
    blink_off_d   = blink_off_q;
    blink_cnt_inc = blink_cnt_q + 1'b1;
`endif

    unique case (state_q)
      IDLE: begin
        if (win_valid) take = 1'b1;
      end
      SHOW: begin
        if (dwell_q != '0) begin
          // While the dwell runs, the display is frozen. Source-side changes
          // to req or pattern are ignored until the dwell expires.
          dwell_d = dwell_q - 1'b1;
`ifdef LED_BLINK_EN
          if (blink_cnt_inc == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_off_d = ~blink_off_q;
          end else begin
            blink_cnt_d = blink_cnt_inc;
          end
          led_d = (blink_en_q && blink_off_d) ? 10'b0 : latched_q;
`endif
        end else if (win_valid) begin
          take = 1'b1;
        end else begin
          // grant_id keeps the last winner so software can see who showed last.
          state_d = IDLE;
          led_d   = IDLE_PATTERN;
          busy_d  = 1'b0;
`ifdef LED_BLINK_EN
          blink_cnt_d = '0;
          blink_off_d = 1'b0;
`endif
        end
      end
    endcase

    // A new grant behaves the same way from IDLE and on re-arbitration.
    if (take) begin
      state_d  = SHOW;
      led_d    = bus.pattern[int'(win_id)*10 +: 10];
      ack_d    = N_REQ'(1) << win_id;
      grant_d  = win_id;
      busy_d   = 1'b1;
      dwell_d  = HOLD_LOAD;
      rr_ptr_d = (win_id == LAST_ID) ? '0 : win_id + 1'b1;
`ifdef LED_BLINK_EN
      latched_d   = bus.pattern[int'(win_id)*10 +: 10];
      blink_en_d  = bus.blink[win_id];
      blink_cnt_d = '0;
      blink_off_d = 1'b0;
`endif
    end
  end

  // State and output registers. Reset aborts any grant in progress, so no
  // ack is left pending after reset is released.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      dwell_q  <= '0;
      rr_ptr_q <= '0;
      led_q    <= IDLE_PATTERN;
      ack_q    <= '0;
      grant_q  <= '0;
      busy_q   <= 1'b0;
`ifdef LED_BLINK_EN
      latched_q   <= '0;
      blink_en_q  <= 1'b0;
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments make all registers update together
      // from the values they had before the clock edge.
      state_q  <= state_d;
      dwell_q  <= dwell_d;
      rr_ptr_q <= rr_ptr_d;
      led_q    <= led_d;
      ack_q    <= ack_d;
      grant_q  <= grant_d;
      busy_q   <= busy_d;
`ifdef LED_BLINK_EN
      latched_q   <= latched_d;
      blink_en_q  <= blink_en_d;
      blink_cnt_q <= blink_cnt_d;
      blink_off_q <= blink_off_d;
`endif
    end
  end

  assign bus.led_out  = led_q;
  assign bus.ack      = ack_q;
  assign bus.grant_id = grant_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_led_status_arbiter.sv
// Directed bench for led_status_arbiter with N_REQ=4 and HOLD_CYCLES=4.
// Build with LED_BLINK_EN to include the blink scenario (BLINK_DIV=2).
module tb_led_status_arbiter;

  localparam int N_REQ = 4;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  led_status_arbiter_if #(.N_REQ(N_REQ)) bus ();

  led_status_arbiter #(
    .N_REQ        (N_REQ),
    .HOLD_CYCLES  (4),
    .IDLE_PATTERN (10'h001)
`ifdef LED_BLINK_EN
    ,
    .BLINK_DIV    (2)
`endif
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock. Outputs are sampled and inputs driven 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pat(input int i, input logic [9:0] v);
    bus.pattern[i*10 +: 10] = v;
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    bus.req     = '0;
    bus.pattern = '0;
`ifdef LED_BLINK_EN
    bus.blink   = '0;
`endif
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if (bus.led_out !== 10'h001 || bus.busy !== 1'b0 || bus.ack !== 4'b0000) begin
        errors++;
        $display("FAIL reset_idle cyc%0d: led=%h busy=%b ack=%b, want led=001 busy=0 ack=0000",
                 c, bus.led_out, bus.busy, bus.ack);
      end
    end
    checks++;
    if (bus.grant_id !== 2'd0) begin
      errors++;
      $display("FAIL reset_grant: grant_id=%0d, want 0", bus.grant_id);
    end
  endtask

  task automatic test_single();
    do_reset();
    bus.req = 4'b0100;
    set_pat(2, 10'h2AA);
    step();
    checks++;
    if (bus.led_out !== 10'h2AA || bus.ack !== 4'b0100 || bus.grant_id !== 2'd2 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL single_grant: led=%h ack=%b gid=%0d busy=%b, want 2aa 0100 2 1",
               bus.led_out, bus.ack, bus.grant_id, bus.busy);
    end
    bus.req = 4'b0000;
    for (int c = 1; c < 4; c++) begin
      step();
      checks++;
      if (bus.led_out !== 10'h2AA || bus.ack !== 4'b0000 || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL single_hold cyc%0d: led=%h ack=%b busy=%b, want 2aa 0000 1",
                 c, bus.led_out, bus.ack, bus.busy);
      end
    end
    step();
    checks++;
    if (bus.led_out !== 10'h001 || bus.busy !== 1'b0 || bus.ack !== 4'b0000 || bus.grant_id !== 2'd2) begin
      errors++;
      $display("FAIL single_idle: led=%h busy=%b ack=%b gid=%0d, want 001 0 0000 2",
               bus.led_out, bus.busy, bus.ack, bus.grant_id);
    end
  endtask

  task automatic test_rotation();
    logic [9:0] pats [4];
    logic [3:0] exp_ack;
    pats[0] = 10'h111;
    pats[1] = 10'h222;
    pats[2] = 10'h333;
    pats[3] = 10'h0CC;
    do_reset();
    for (int i = 0; i < 4; i++) set_pat(i, pats[i]);
    bus.req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        exp_ack = (c == 0) ? (4'b0001 << (n % 4)) : 4'b0000;
        checks++;
        if (bus.led_out !== pats[n % 4] || bus.ack !== exp_ack ||
            bus.grant_id !== 2'(n % 4) || bus.busy !== 1'b1) begin
          errors++;
          $display("FAIL rotation g%0d c%0d: led=%h ack=%b gid=%0d busy=%b, want %h %b %0d 1",
                   n, c, bus.led_out, bus.ack, bus.grant_id, bus.busy,
                   pats[n % 4], exp_ack, n % 4);
        end
      end
    end
    bus.req = 4'b0000;
  endtask

  task automatic test_freeze();
    do_reset();
    bus.req = 4'b0010;
    set_pat(1, 10'h155);
    step();
    checks++;
    if (bus.led_out !== 10'h155 || bus.ack !== 4'b0010 || bus.grant_id !== 2'd1) begin
      errors++;
      $display("FAIL freeze_grant: led=%h ack=%b gid=%0d, want 155 0010 1",
               bus.led_out, bus.ack, bus.grant_id);
    end
    step();
    bus.req = 4'b0000;
    set_pat(1, 10'h0F0);
    for (int c = 2; c < 4; c++) begin
      step();
      checks++;
      if (bus.led_out !== 10'h155 || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL freeze_hold cyc%0d: led=%h busy=%b, want 155 1", c, bus.led_out, bus.busy);
      end
    end
    step();
    checks++;
    if (bus.led_out !== 10'h001 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL freeze_idle: led=%h busy=%b, want 001 0", bus.led_out, bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.req = 4'b0010;
    set_pat(1, 10'h1E1);
    step();
    step();
    step();
    step();
    checks++;
    if (bus.ack !== 4'b0000 || bus.led_out !== 10'h1E1) begin
      errors++;
      $display("FAIL b2b_last_dwell: ack=%b led=%h, want 0000 1e1", bus.ack, bus.led_out);
    end
    step();
    checks++;
    if (bus.ack !== 4'b0010 || bus.grant_id !== 2'd1 || bus.busy !== 1'b1 || bus.led_out !== 10'h1E1) begin
      errors++;
      $display("FAIL b2b_regrant: ack=%b gid=%0d busy=%b led=%h, want 0010 1 1 1e1",
               bus.ack, bus.grant_id, bus.busy, bus.led_out);
    end
    bus.req = 4'b0000;
  endtask

  task automatic test_reset_mid_show();
    do_reset();
    bus.req = 4'b0100;
    set_pat(2, 10'h2AA);
    step();
    step();
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.led_out !== 10'h001 || bus.ack !== 4'b0000 || bus.busy !== 1'b0 || bus.grant_id !== 2'd0) begin
      errors++;
      $display("FAIL async_reset: led=%h ack=%b busy=%b gid=%0d, want 001 0000 0 0",
               bus.led_out, bus.ack, bus.busy, bus.grant_id);
    end
    bus.req = 4'b0001;
    set_pat(0, 10'h0C3);
    #2;
    reset_n = 1'b1;
    step();
    checks++;
    if (bus.ack !== 4'b0001 || bus.grant_id !== 2'd0 || bus.led_out !== 10'h0C3 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_grant: ack=%b gid=%0d led=%h busy=%b, want 0001 0 0c3 1",
               bus.ack, bus.grant_id, bus.led_out, bus.busy);
    end
    bus.req = 4'b0000;
  endtask

`ifdef LED_BLINK_EN
  task automatic test_blink();
    logic [9:0] exp_seq [4];
    exp_seq[0] = 10'h3FF;
    exp_seq[1] = 10'h3FF;
    exp_seq[2] = 10'h000;
    exp_seq[3] = 10'h000;
    do_reset();
    bus.req   = 4'b1000;
    bus.blink = 4'b1000;
    set_pat(3, 10'h3FF);
    for (int c = 0; c < 4; c++) begin
      step();
      if (c == 0) bus.req = 4'b0000;
      checks++;
      if (bus.led_out !== exp_seq[c]) begin
        errors++;
        $display("FAIL blink cyc%0d: led=%h, want %h", c, bus.led_out, exp_seq[c]);
      end
    end
    step();
    checks++;
    if (bus.led_out !== 10'h001 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL blink_idle: led=%h busy=%b, want 001 0", bus.led_out, bus.busy);
    end
  endtask
`endif

  initial begin
    checks      = 0;
    errors      = 0;
    reset_n     = 1'b0;
    bus.req     = '0;
    bus.pattern = '0;
`ifdef LED_BLINK_EN
    bus.blink   = '0;
`endif
    #2;
    test_reset();
    test_single();
    test_rotation();
    test_freeze();
    test_back_to_back();
    test_reset_mid_show();
`ifdef LED_BLINK_EN
    test_blink();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
